// File: rtl/simon_data_in_unpack.sv
// simon_data_in_unpack: captures a packed packet (info, count, 4N-bit payload)
// and hands it to a SIMON core either as a 4-word key or as two 2-word blocks,
// using newKey/loadKey and newData/loadData handshakes.
// Optional feature macro: SIMON_DATAIN_PKTCHK_EN. When defined, packets whose
// info byte has bit 7 clear are discarded.
module simon_data_in_unpack #(
  parameter int N    = 16,
  parameter int M    = 4,
  parameter int T    = 32,
  parameter int Cb   = 5,
  parameter int MODE = 0
) (
  input  logic                    clk,
  input  logic                    nR,
  input  logic                    newPkt,
  input  logic                    loadData,
  input  logic                    loadKey,
  input  logic [(N/2+2)*8-1:0]    in,
  output logic                    loadPkt,
  output logic                    donePkt,
  output logic                    newKey,
  output logic                    newData,
  output logic [7:0]              infoIN,
  output logic [7:0]              countIN,
  output logic [1:0][N-1:0]       blockIN,
  output logic [M-1:0][N-1:0]     KEY
);

  localparam int W  = (N/2+2)*8;
  localparam int PW = 4*N;

  // The key is one full payload and the word width must split into bytes.
  // The round/mode parameters only exist for interface compatibility.
  if ((N % 2) != 0 || M != 4 || T < 0 || Cb < 0 || MODE < 0) begin : g_bad_config
  end

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_KEY_WAIT  = 3'd2;
  localparam logic [2:0] S_DATA_WAIT = 3'd3;
  localparam logic [2:0] S_RELEASE   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_REARM     = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [PW-1:0]        payload_q, payload_d;
  logic [7:0]           info_q, info_d;
  logic [7:0]           count_q, count_d;
  logic                 load_pkt_q, load_pkt_d;
  logic                 done_pkt_q, done_pkt_d;
  logic                 new_key_q, new_key_d;
  logic                 new_data_q, new_data_d;
  logic [1:0][N-1:0]    block_q, block_d;
  logic [M-1:0][N-1:0]  key_q, key_d;
  logic                 is_key_q, is_key_d;
  logic                 second_q, second_d;
  logic                 pkt_ok;
  logic                 rel_ack;

`ifdef SIMON_DATAIN_PKTCHK_EN
  assign pkt_ok = info_q[7];
`else
  assign pkt_ok = 1'b1;
`endif

  assign loadPkt = load_pkt_q;
  assign donePkt = done_pkt_q;
  assign newKey  = new_key_q;
  assign newData = new_data_q;
  assign infoIN  = info_q;
  assign countIN = count_q;
  assign blockIN = block_q;
  assign KEY     = key_q;

  // Next-state and next-register logic for the unpack sequence.
  always_comb begin
    state_d    = state_q;
    payload_d  = payload_q;
    info_d     = info_q;
    count_d    = count_q;
    load_pkt_d = 1'b0;
    done_pkt_d = 1'b0;
    new_key_d  = new_key_q;
    new_data_d = new_data_q;
    block_d    = block_q;
    key_d      = key_q;
    is_key_d   = is_key_q;
    second_d   = second_q;
    rel_ack    = is_key_q ? loadKey : loadData;

    case (state_q)
      S_IDLE: begin
        if (newPkt) begin
          payload_d  = in[PW-1:0];
          info_d     = in[W-1 -: 8];
          count_d    = in[W-9 -: 8];
          load_pkt_d = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!pkt_ok) begin
          state_d = S_DONE;
        end else if (info_q[5]) begin
          key_d     = payload_q;
          is_key_d  = 1'b1;
          second_d  = 1'b0;
          new_key_d = 1'b1;
          state_d   = S_KEY_WAIT;
        end else begin
          block_d    = payload_q[PW-1:2*N];
          is_key_d   = 1'b0;
          second_d   = 1'b1;
          new_data_d = 1'b1;
          state_d    = S_DATA_WAIT;
        end
      end
      S_KEY_WAIT: begin
        if (loadKey && new_key_q) begin
          new_key_d = 1'b0;
          state_d   = S_RELEASE;
        end
      end
      S_DATA_WAIT: begin
        if (loadData && new_data_q) begin
          new_data_d = 1'b0;
          state_d    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!rel_ack) begin
          if (!is_key_q && second_q) begin
            block_d    = payload_q[2*N-1:0];
            second_d   = 1'b0;
            new_data_d = 1'b1;
            state_d    = S_DATA_WAIT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_pkt_d = 1'b1;
        state_d    = S_REARM;
      end
      S_REARM: begin
        if (!newPkt) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register update with synchronous active-low reset that clears everything.
  always_ff @(posedge clk) begin
    if (!nR) begin
      state_q    <= S_IDLE;
      payload_q  <= '0;
      info_q     <= '0;
      count_q    <= '0;
      load_pkt_q <= 1'b0;
      done_pkt_q <= 1'b0;
      new_key_q  <= 1'b0;
      new_data_q <= 1'b0;
      block_q    <= '0;
      key_q      <= '0;
      is_key_q   <= 1'b0;
      second_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      payload_q  <= payload_d;
      info_q     <= info_d;
      count_q    <= count_d;
      load_pkt_q <= load_pkt_d;
      done_pkt_q <= done_pkt_d;
      new_key_q  <= new_key_d;
      new_data_q <= new_data_d;
      block_q    <= block_d;
      key_q      <= key_d;
      is_key_q   <= is_key_d;
      second_q   <= second_d;
    end
  end

endmodule

// File: tb/tb_simon_data_in_unpack.sv
// tb_simon_data_in_unpack: directed self-checking bench for simon_data_in_unpack
// (N=16, M=4). Honours SIMON_DATAIN_PKTCHK_EN for the info-bit-7 filter step.
module tb_simon_data_in_unpack;

  logic             clk = 1'b0;
  logic             nR = 1'b0;
  logic             newPkt = 1'b0;
  logic             loadData = 1'b0;
  logic             loadKey = 1'b0;
  logic [79:0]      pkt = '0;
  logic             loadPkt, donePkt, newKey, newData;
  logic [7:0]       infoIN, countIN;
  logic [1:0][15:0] blockIN;
  logic [3:0][15:0] KEY;

  int n_compared = 0;
  int n_mismatched = 0;
  int load_cnt, done_cnt, key_cnt;

  simon_data_in_unpack #(.N(16), .M(4), .T(32), .Cb(5), .MODE(0)) dut (
    .clk(clk), .nR(nR), .newPkt(newPkt), .loadData(loadData), .loadKey(loadKey),
    .in(pkt), .loadPkt(loadPkt), .donePkt(donePkt), .newKey(newKey),
    .newData(newData), .infoIN(infoIN), .countIN(countIN), .blockIN(blockIN),
    .KEY(KEY)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with its hand-computed expectation.
  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run a fixed number of cycles counting loadPkt/donePkt pulses and newKey-high cycles.
  task automatic watch(input int cycles, output int loads, output int dones, output int keys);
    loads = 0; dones = 0; keys = 0;
    for (int i = 0; i < cycles; i++) begin
      apply_stimulus();
      if (loadPkt) loads++;
      if (donePkt) dones++;
      if (newKey) keys++;
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    $display("[TB] start");

    // Reset for two cycles: everything clears.
    nR = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("rst_loadPkt", {63'd0, loadPkt}, 64'd0);
    check_output("rst_donePkt", {63'd0, donePkt}, 64'd0);
    check_output("rst_newKey",  {63'd0, newKey}, 64'd0);
    check_output("rst_newData", {63'd0, newData}, 64'd0);
    check_output("rst_info",    {56'd0, infoIN}, 64'd0);
    check_output("rst_count",   {56'd0, countIN}, 64'd0);
    check_output("rst_block",   {32'd0, blockIN}, 64'd0);
    check_output("rst_key",     KEY, 64'd0);
    nR = 1'b1;

    // Key packet.
    pkt = 80'hA0001918111009080100;
    newPkt = 1'b1;
    apply_stimulus();
    check_output("k_loadPkt", {63'd0, loadPkt}, 64'd1);
    check_output("k_info",    {56'd0, infoIN}, 64'hA0);
    check_output("k_count",   {56'd0, countIN}, 64'h00);
    newPkt = 1'b0;
    pkt = '0;
    apply_stimulus();
    check_output("k_loadPkt_once", {63'd0, loadPkt}, 64'd0);
    check_output("k_newKey", {63'd0, newKey}, 64'd1);
    check_output("k_key", KEY, 64'h1918111009080100);
    // Wrong acknowledge has no effect.
    loadData = 1'b1;
    apply_stimulus();
    check_output("k_wrong_ack_newKey", {63'd0, newKey}, 64'd1);
    check_output("k_wrong_ack_newData", {63'd0, newData}, 64'd0);
    loadData = 1'b0;
    loadKey = 1'b1;
    apply_stimulus();
    check_output("k_ack_newKey", {63'd0, newKey}, 64'd0);
    apply_stimulus();
    loadKey = 1'b0;
    watch(6, load_cnt, done_cnt, key_cnt);
    check_output("k_done_pulses", 64'(done_cnt), 64'd1);
    check_output("k_no_reload", 64'(load_cnt), 64'd0);

    // Data packet with two blocks.
    pkt = 80'h80016565687721403F21;
    newPkt = 1'b1;
    apply_stimulus();
    check_output("d_loadPkt", {63'd0, loadPkt}, 64'd1);
    check_output("d_info",    {56'd0, infoIN}, 64'h80);
    check_output("d_count",   {56'd0, countIN}, 64'h01);
    newPkt = 1'b0;
    pkt = 80'hFFFFFFFFFFFFFFFFFFFF;
    apply_stimulus();
    check_output("d_block1", {32'd0, blockIN}, 64'h65656877);
    check_output("d_newData1", {63'd0, newData}, 64'd1);
    loadData = 1'b1;
    apply_stimulus();
    check_output("d_ack1_newData", {63'd0, newData}, 64'd0);
    apply_stimulus();
    loadData = 1'b0;
    apply_stimulus();
    check_output("d_block2", {32'd0, blockIN}, 64'h21403F21);
    check_output("d_newData2", {63'd0, newData}, 64'd1);
    check_output("d_key_kept", KEY, 64'h1918111009080100);
    check_output("d_no_early_done", {63'd0, donePkt}, 64'd0);
    loadData = 1'b1;
    apply_stimulus();
    check_output("d_ack2_newData", {63'd0, newData}, 64'd0);
    loadData = 1'b0;
    watch(6, load_cnt, done_cnt, key_cnt);
    check_output("d_done_pulses", 64'(done_cnt), 64'd1);
    check_output("d_block_kept", {32'd0, blockIN}, 64'h21403F21);

    // newPkt held high through the whole packet: exactly one capture.
    pkt = 80'hA000_0123_4567_89AB_CDEF;
    newPkt = 1'b1;
    apply_stimulus();
    check_output("h_loadPkt", {63'd0, loadPkt}, 64'd1);
    apply_stimulus();
    check_output("h_key", KEY, 64'h0123456789ABCDEF);
    loadKey = 1'b1;
    apply_stimulus();
    loadKey = 1'b0;
    watch(8, load_cnt, done_cnt, key_cnt);
    check_output("h_done_pulses", 64'(done_cnt), 64'd1);
    check_output("h_no_second_load", 64'(load_cnt), 64'd0);
    newPkt = 1'b0;
    apply_stimulus();
    newPkt = 1'b1;
    apply_stimulus();
    check_output("h_recapture", {63'd0, loadPkt}, 64'd1);
    newPkt = 1'b0;
    apply_stimulus();
    loadKey = 1'b1;
    apply_stimulus();
    loadKey = 1'b0;
    watch(6, load_cnt, done_cnt, key_cnt);
    check_output("h_done2_pulses", 64'(done_cnt), 64'd1);

    // Reset in the middle of a data handshake.
    pkt = 80'h80016565687721403F21;
    newPkt = 1'b1;
    apply_stimulus();
    newPkt = 1'b0;
    apply_stimulus();
    check_output("r_newData_before", {63'd0, newData}, 64'd1);
    nR = 1'b0;
    apply_stimulus();
    check_output("r_newData", {63'd0, newData}, 64'd0);
    check_output("r_block",   {32'd0, blockIN}, 64'd0);
    check_output("r_key",     KEY, 64'd0);
    check_output("r_info",    {56'd0, infoIN}, 64'd0);
    check_output("r_count",   {56'd0, countIN}, 64'd0);
    nR = 1'b1;
    pkt = 80'hA0001918111009080100;
    newPkt = 1'b1;
    apply_stimulus();
    check_output("r_loadPkt", {63'd0, loadPkt}, 64'd1);
    newPkt = 1'b0;
    apply_stimulus();
    check_output("r_newKey", {63'd0, newKey}, 64'd1);
    check_output("r_key_new", KEY, 64'h1918111009080100);
    loadKey = 1'b1;
    apply_stimulus();
    loadKey = 1'b0;
    watch(6, load_cnt, done_cnt, key_cnt);
    check_output("r_done_pulses", 64'(done_cnt), 64'd1);

    // Key packet with info bit 7 clear.
    pkt = 80'h2000_AAAA_BBBB_CCCC_DDDD;
    newPkt = 1'b1;
    apply_stimulus();
    newPkt = 1'b0;
`ifdef SIMON_DATAIN_PKTCHK_EN
    watch(6, load_cnt, done_cnt, key_cnt);
    check_output("f_done_pulses", 64'(done_cnt), 64'd1);
    check_output("f_newKey_cycles", 64'(key_cnt), 64'd0);
    check_output("f_key_kept", KEY, 64'h1918111009080100);
`else
    apply_stimulus();
    check_output("f_newKey", {63'd0, newKey}, 64'd1);
    check_output("f_key", KEY, 64'hAAAABBBBCCCCDDDD);
    loadKey = 1'b1;
    apply_stimulus();
    loadKey = 1'b0;
    watch(6, load_cnt, done_cnt, key_cnt);
    check_output("f_done_pulses", 64'(done_cnt), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/simon_data_in_unpack.md
SIMON_DATA_IN_UNPACK -- requirements
Module: simon_data_in_unpack

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N, 16, SIMON word width in bits; must be a multiple of 2.
- M, 4, key words; must equal 4, so the key is exactly one packet payload.
- T, 32, round count; accepted, unused.
- Cb, 5, round-counter width; accepted, unused.
- MODE, 0, cipher mode; accepted, unused.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state changes on the rising edge.
- nR, in, 1, reset; synchronous, active-low.
- newPkt, in, 1, a packet is valid on in.
- loadData, in, 1, consumer acknowledges blockIN.
- loadKey, in, 1, consumer acknowledges KEY.
- in, in, (N/2+2) bytes, packet; byte N/2+1 = info, byte N/2 = count, bytes N/2-1..0 = payload (4N bits).
- loadPkt, out, 1, one-cycle pulse: packet captured.
- donePkt, out, 1, one-cycle pulse: packet fully delivered.
- newKey, out, 1, KEY valid, awaiting loadKey.
- newData, out, 1, blockIN valid, awaiting loadData.
- infoIN, out, 8, captured info byte.
- countIN, out, 8, captured count byte.
- blockIN, out, 2 words of N bits, current plaintext block.
- KEY, out, M words of N bits, key register.

Function
REQ-003 FSM states: IDLE, DECODE, KEY_WAIT, DATA_WAIT, RELEASE, DONE, REARM.
REQ-004 Capture (IDLE with newPkt=1):
- Register the whole of in.
- Drive infoIN and countIN from the captured bytes.
- Pulse loadPkt for exactly one cycle, on the same edge as the capture.
- Go to DECODE.
- The in port may change on the cycle after loadPkt without affecting the captured packet.
REQ-005 Decode (DECODE) by captured infoIN[5]:
- 1 = key packet.
- 0 = data packet.
REQ-006 Key packet:
- KEY[3] is the most significant payload word, down to KEY[0] as the least significant.
- Assert newKey and go to KEY_WAIT.
- In KEY_WAIT, loadKey=1 clears newKey and goes to RELEASE; the next step is DONE.
REQ-007 Data packet:
- The payload holds two blocks, each of 2N bits.
- First block (upper 2N payload bits): blockIN[1] = upper word, blockIN[0] = lower word.
- Assert newData and go to DATA_WAIT.
- In DATA_WAIT, loadData=1 clears newData and goes to RELEASE.
REQ-008 RELEASE:
- Wait until the active acknowledge (loadKey or loadData) returns to 0.
- Then, for a data packet with the second block still pending: present the second block, re-assert newData, return to DATA_WAIT.
- Otherwise go to DONE.
REQ-009 DONE:
- Pulse donePkt for exactly one cycle.
- Go to REARM.
REQ-010 REARM returns to IDLE once newPkt=0, so a level-held newPkt never captures twice.
REQ-011 newPkt is ignored outside IDLE.
REQ-012 Register persistence:
- KEY holds its value until the next key packet.
- blockIN holds its value until the next block is presented.
REQ-013 An acknowledge asserted while its new* flag is low has no effect.

Reset
REQ-014 nR=0 sampled at a clock edge forces:
- State IDLE.
- All outputs 0, including KEY, blockIN, infoIN and countIN.
- This applies at any time, including mid-handshake, and discards any pending packet.
REQ-015 Operation resumes on the first edge with nR=1.

Configuration
REQ-016 Macro SIMON_DATAIN_PKTCHK_EN:
- Defined: in DECODE, a packet with infoIN[7]=0 is discarded. It produces no newKey or newData, donePkt still pulses, and KEY and blockIN are unchanged.
- Undefined: bit 7 is ignored and every packet is processed.

Verification (N=16, M=4)
REQ-017 Apply nR=0 for 2 cycles -> every output equals 0.
REQ-018 Key packet: in=A0001918111009080100 with newPkt=1 ->
- loadPkt pulses once.
- infoIN=A0, countIN=00.
- KEY={1918,1110,0908,0100}, newKey=1.
- After a loadKey pulse of 2 cycles: newKey=0, then donePkt pulses once.
REQ-019 Data packet: in=80016565687721403F21 with newPkt=1 ->
- blockIN={6565,6877}, newData=1.
- loadData high 2 cycles -> newData=0.
- After loadData falls: blockIN={2140,3F21}, newData=1 again.
- Second acknowledge -> donePkt pulses once.
- KEY unchanged.
REQ-020 Hold newPkt high through donePkt -> no second loadPkt until newPkt has returned to 0.
REQ-021 Drive nR=0 during DATA_WAIT -> outputs clear; the next packet is processed normally.
REQ-022 With SIMON_DATAIN_PKTCHK_EN defined, info=20 -> donePkt pulses, newKey stays 0, KEY unchanged.
